// File: rtl/async_pipe_source.sv
// Clocked source for the async pipeline: valid/ready FIFO feeding a 4-phase bundled-data request.
// Optional HS_TIMEOUT_EN adds a sticky per-phase handshake timeout flag; otherwise err_timeout is 0.
module async_pipe_source #(
  parameter int DW          = 8,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_data,
  output logic                       valid_out,
  output logic [DW-1:0]              data_out,
  input  logic                       ack_in,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, REQ, RTZ} state_t;

  state_t            state_reg;
  logic              ack_meta_reg;
  logic              ack_s_reg;
  logic              ready_en_reg;
  logic              valid_out_reg;
  logic [DW-1:0]     data_out_reg;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic [DW-1:0]     mem [DEPTH];

  logic push;
  logic pop;

  // ready is held low until the first edge after reset release
  assign in_ready   = ready_en_reg && (level_reg < LW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state_reg == IDLE) && (level_reg != '0) && !ack_s_reg;
  assign valid_out  = valid_out_reg;
  assign data_out   = data_out_reg;
  assign fifo_level = level_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta_reg <= 1'b0;
      ack_s_reg    <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      ack_meta_reg <= ack_in;
      ack_s_reg    <= ack_meta_reg;
      ready_en_reg <= 1'b1;
    end
  end

  // storage carries no reset so it can map onto RAM
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push && !pop)      level_reg <= level_reg + LW'(1);
      else if (pop && !push) level_reg <= level_reg - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      valid_out_reg <= 1'b0;
      data_out_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
            data_out_reg <= mem[rd_ptr_reg];
            state_reg    <= SETUP;
          end
        end
        SETUP: begin
          valid_out_reg <= 1'b1;
          state_reg     <= REQ;
        end
        REQ: begin
          if (ack_s_reg) begin
            valid_out_reg <= 1'b0;
            state_reg     <= RTZ;
          end
        end
        RTZ: begin
          if (!ack_s_reg) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef HS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_reg;
  logic          err_reg;
  logic          phase_enter;
  logic          phase_stay;

  assign phase_enter = (state_reg == SETUP) || ((state_reg == REQ) && ack_s_reg);
  assign phase_stay  = ((state_reg == REQ) && !ack_s_reg) || ((state_reg == RTZ) && ack_s_reg);
  assign err_timeout = err_reg;

  // counter saturates at the limit; the handshake keeps waiting regardless
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else if (phase_enter) begin
      cnt_reg <= '0;
    end else if (phase_stay && (cnt_reg != CW'(TIMEOUT_CYC))) begin
      cnt_reg <= cnt_reg + CW'(1);
      if (cnt_reg == CW'(TIMEOUT_CYC - 1)) err_reg <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign err_timeout    = 1'b0;
`endif

endmodule
